// File: rtl/fft_ctrl_if.sv
// Control and memory-addressing bundle between the FFT sequencer and its datapath.
// The slave side is the sequencer; the master side issues start/abort and consumes addresses.
interface fft_ctrl_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned SW     = 2
);
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic [SW-1:0]     stage;
    logic              first_stage;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_first;
    logic [ADDR_W-1:0] rd_addr_second;
    logic [ADDR_W-2:0] tw_addr;
    logic              rd_bank;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr_first;
    logic [ADDR_W-1:0] wr_addr_second;
    logic              wr_bank;
    logic              result_bank;

    modport master (
        output start, abort,
        input  busy, done, stage, first_stage, rd_en, rd_addr_first, rd_addr_second,
               tw_addr, rd_bank, wr_en, wr_addr_first, wr_addr_second, wr_bank, result_bank
    );

    modport slave (
        input  start, abort,
        output busy, done, stage, first_stage, rd_en, rd_addr_first, rd_addr_second,
               tw_addr, rd_bank, wr_en, wr_addr_first, wr_addr_second, wr_bank, result_bank
    );
endinterface

// File: rtl/fft_ctrl_rtl.sv
// Radix-2 DIT FFT sequencer: issues butterfly read pairs and twiddle indices stage by stage,
// replays write addresses after the datapath latency, and ping-pongs the sample banks.
module fft_ctrl_rtl #(
    parameter int unsigned N_POINTS = 8,
    parameter int unsigned PIPE_LAT = 6
) (
    input  logic       clk,
    input  logic       reset,
    fft_ctrl_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(N_POINTS);
    localparam int unsigned S      = ADDR_W;
    localparam int unsigned SW     = ($clog2(S) > 0) ? $clog2(S) : 1;
    localparam int unsigned K_W    = ADDR_W - 1;
    localparam int unsigned TW_W   = ADDR_W - 1;
    localparam int unsigned D_W    = ($clog2(PIPE_LAT) > 0) ? $clog2(PIPE_LAT) : 1;

    localparam logic [K_W-1:0] K_LAST = K_W'(N_POINTS / 2 - 1);
    localparam logic [SW-1:0]  S_LAST = SW'(S - 1);
    localparam logic [D_W-1:0] D_LAST = D_W'(PIPE_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_n;
    logic [K_W-1:0]    k, k_n;
    logic [SW-1:0]     stage, stage_n;
    logic [D_W-1:0]    dcnt, dcnt_n;

    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic [SW-1:0]     stage_q, stage_o_n;
    logic              first_q, first_n;
    logic              rd_en_q, rd_en_n;
    logic [ADDR_W-1:0] rd_a1_q, rd_a1_n;
    logic [ADDR_W-1:0] rd_a2_q, rd_a2_n;
    logic [TW_W-1:0]   tw_q, tw_n;
    logic              rd_bank_q, rd_bank_n;
    logic              wr_bank_q, wr_bank_n;
    logic              result_q, result_n;

    logic [ADDR_W-1:0] kk, mask;

    logic [PIPE_LAT-1:0]             pipe_v;
    logic [PIPE_LAT-1:0][ADDR_W-1:0] pipe_a1;
    logic [PIPE_LAT-1:0][ADDR_W-1:0] pipe_a2;

    // Next state plus look-ahead outputs, so every output register shows the new state's values.
    always_comb begin
        state_n   = state;
        k_n       = k;
        stage_n   = stage;
        dcnt_n    = dcnt;
        done_n    = 1'b0;
        result_n  = result_q;
        rd_a1_n   = '0;
        rd_a2_n   = '0;
        tw_n      = '0;

        case (state)
            IDLE, DONE: begin
                // DONE behaves as an idle slot so back-to-back runs lose no cycle
                if (bus.start) begin
                    state_n = ISSUE;
                    k_n     = '0;
                    stage_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (k == K_LAST) begin
                    state_n = DRAIN;
                    dcnt_n  = '0;
                end else begin
                    k_n = k + K_W'(1);
                end
            end
            DRAIN: begin
                if (dcnt == D_LAST) begin
                    if (stage == S_LAST) begin
                        state_n  = DONE;
                        done_n   = 1'b1;
                        result_n = ~stage[0];
                    end else begin
                        state_n = ISSUE;
                        stage_n = stage + SW'(1);
                        k_n     = '0;
                    end
                end else begin
                    dcnt_n = dcnt + D_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (bus.abort) begin
            state_n  = IDLE;
            k_n      = '0;
            stage_n  = '0;
            dcnt_n   = '0;
            done_n   = 1'b0;
            result_n = result_q;
        end

        busy_n    = (state_n == ISSUE) || (state_n == DRAIN);
        rd_en_n   = (state_n == ISSUE);
        stage_o_n = busy_n ? stage_n : '0;
        first_n   = busy_n && (stage_n == '0);
        rd_bank_n = busy_n && stage_n[0];
        wr_bank_n = busy_n && !stage_n[0];

        // Group base doubles (k with low s bits cleared, shifted left); partner sits h above.
        kk   = ADDR_W'(k_n);
        mask = (ADDR_W'(1) << stage_n) - ADDR_W'(1);
        if (rd_en_n) begin
            rd_a1_n = ((kk & ~mask) << 1) | (kk & mask);
            rd_a2_n = rd_a1_n | (mask + ADDR_W'(1));
            tw_n    = TW_W'((kk & mask) << (S_LAST - stage_n));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            k         <= '0;
            stage     <= '0;
            dcnt      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stage_q   <= '0;
            first_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_a1_q   <= '0;
            rd_a2_q   <= '0;
            tw_q      <= '0;
            rd_bank_q <= 1'b0;
            wr_bank_q <= 1'b0;
            result_q  <= 1'b0;
        end else begin
            state     <= state_n;
            k         <= k_n;
            stage     <= stage_n;
            dcnt      <= dcnt_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            stage_q   <= stage_o_n;
            first_q   <= first_n;
            rd_en_q   <= rd_en_n;
            rd_a1_q   <= rd_a1_n;
            rd_a2_q   <= rd_a2_n;
            tw_q      <= tw_n;
            rd_bank_q <= rd_bank_n;
            wr_bank_q <= wr_bank_n;
            result_q  <= result_n;
        end
    end

    // Write-address replay line; abort flushes it so no stale write escapes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_v  <= '0;
            pipe_a1 <= '0;
            pipe_a2 <= '0;
        end else if (bus.abort) begin
            pipe_v  <= '0;
            pipe_a1 <= '0;
            pipe_a2 <= '0;
        end else begin
            pipe_v[0]  <= rd_en_q;
            pipe_a1[0] <= rd_a1_q;
            pipe_a2[0] <= rd_a2_q;
            for (int i = 1; i < int'(PIPE_LAT); i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_a1[i] <= pipe_a1[i-1];
                pipe_a2[i] <= pipe_a2[i-1];
            end
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.stage          = stage_q;
    assign bus.first_stage    = first_q;
    assign bus.rd_en          = rd_en_q;
    assign bus.rd_addr_first  = rd_a1_q;
    assign bus.rd_addr_second = rd_a2_q;
    assign bus.tw_addr        = tw_q;
    assign bus.rd_bank        = rd_bank_q;
    assign bus.wr_en          = pipe_v[PIPE_LAT-1];
    assign bus.wr_addr_first  = pipe_a1[PIPE_LAT-1];
    assign bus.wr_addr_second = pipe_a2[PIPE_LAT-1];
    assign bus.wr_bank        = wr_bank_q;
    assign bus.result_bank    = result_q;
endmodule
